drawing_slot_scheduler: RTL and testbench
=========================================

// Module: drawing_slot_scheduler
// PURPOSE
//   Per-pixel scheduler for the drawing datapath's shared sprite comparator and data selector.
//   On each pixel_start it scans the enabled sprite slots in priority order (slot 0 highest).
//   For each slot it issues one comparison, stops at the first hit, then issues one select and one store.
//   It sits between the VGA timing generator and the comparator/selector registers.
// PARAMETERS
//   N_SLOTS  8  number of sprite slots sharing the comparator
//   SLOT_W   3  slot index width, = clog2(N_SLOTS)
// PORTS
//   clk          in   1        system clock; all logic on posedge
//   reset        in   1        synchronous, active-high reset
//   pixel_start  in   1        1-cycle pulse: next pixel coordinates are stable
//   is_pixel     in   1        pixel is in the active area; qualifies pixel_start
//   slot_mask    in   N_SLOTS  slot enables; latched when a pixel is accepted
//   comp_hit     in   1        comparator result for slot_idx; valid during CAPTURE
//   clr_overrun  in   1        clears the overrun flag
//   busy         out  1        high in ISSUE, CAPTURE and SELECT
//   comp_en      out  1        comparator refresh strobe (ISSUE)
//   slot_idx     out  SLOT_W   slot under comparison; held through ISSUE and CAPTURE
//   sel_en       out  1        selector refresh strobe (SELECT)
//   sel_slot     out  SLOT_W   winning slot; 0 when sel_bg=1
//   sel_bg       out  1        select background (no hit, or aborted)
//   px_valid     out  1        store strobe; result registers load (STORE)
//   overrun      out  1        sticky: a pixel_start arrived while busy
// BEHAVIOUR
//   Reset: state IDLE; every output 0; latched mask 0; overrun 0. Reset mid-scan abandons the pixel with no strobes.
//   Outputs are registered Moore outputs of the state. Each strobe lasts exactly 1 cycle per state visit.
//   States: IDLE, ISSUE, CAPTURE, SELECT, STORE.
//   Pixel acceptance:
//     - A pixel is accepted when pixel_start=1 and is_pixel=1 in IDLE or STORE. Back-to-back pixels are allowed.
//     - On acceptance, slot_mask is latched.
//     - If the mask has any enabled slot, next state is ISSUE with slot_idx = lowest enabled slot.
//     - If the mask is 0, next state is SELECT with sel_bg=1.
//   pixel_start with is_pixel=0: ignored, no strobes.
//   ISSUE -> CAPTURE unconditionally.
//   CAPTURE transitions:
//     - comp_hit=1: SELECT, with sel_slot=slot_idx and sel_bg=0.
//     - Miss, more enabled slots above: ISSUE with the next higher enabled slot. Disabled slots cost 0 cycles.
//     - Miss on the last enabled slot: SELECT with sel_bg=1.
//   SELECT -> STORE -> IDLE, or STORE -> ISSUE/SELECT if a new pixel is accepted in STORE.
//   Timing, with pixel accepted at cycle t and slot k = j-th enabled slot (j from 0):
//     - comp_en at cycle t+1+2j.
//     - Hit: sel_en at t+3+2j, px_valid at t+4+2j.
//     - All e enabled slots miss: sel_en at t+1+2e, px_valid at t+2+2e.
//     - Worst case: px_valid at t+2+2*N_SLOTS.
//   Overrun (pixel_start=1 during ISSUE, CAPTURE or SELECT, regardless of is_pixel):
//     - overrun is set next cycle and the new pixel is dropped.
//     - In ISSUE or CAPTURE: the scan aborts. Next state is SELECT with sel_bg=1, then STORE. comp_hit that cycle is ignored.
//     - In SELECT: the flag is set only; the current result is unchanged.
//   overrun clears on clr_overrun=1. Setting wins if set and clear happen in the same cycle.
//   slot_mask changes after acceptance have no effect until the next pixel.
//   slot_idx/sel_slot are always < N_SLOTS. Slot indices do not wrap; the scan ends at the highest enabled slot.
// TESTING (N_SLOTS=8)
//   1. mask=8'hFF, comp_hit=1 on slot 0, start at t
//      -> comp_en@t+1 (idx 0), sel_en@t+3 sel_slot=0 sel_bg=0, px_valid@t+4.
//   2. mask=8'hFF, hit only on slot 3
//      -> comp_en@t+1,3,5,7 (idx 0..3), sel_en@t+9 sel_slot=3, px_valid@t+10.
//   3. mask=8'b0010_0100, no hits
//      -> comp_en idx 2@t+1 and idx 5@t+3, sel_en@t+5 sel_bg=1, px_valid@t+6.
//   4. mask=0 -> sel_en@t+1 sel_bg=1, px_valid@t+2. A start with is_pixel=0 -> no strobes.
//   5. mask=8'hFF, no hits, second pixel_start at t+3
//      -> overrun=1@t+4, sel_en@t+4 sel_bg=1, px_valid@t+5.
//      -> clr_overrun@t+7 -> overrun=0@t+8.
//   6. Back-to-back: start in STORE accepted (next comp_en the following cycle).
//      -> reset=1 during CAPTURE -> all outputs 0 and IDLE next cycle, no px_valid.

Source files
------------

// File: rtl/drawing_slot_scheduler.sv
// Per-pixel scheduler for the shared sprite comparator/selector: scans enabled
// slots lowest-first, stops at the first hit, then issues one select and one store.
module drawing_slot_scheduler #(
  parameter int N_SLOTS = 8,
  parameter int SLOT_W  = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pixel_start,
  input  logic               i_is_pixel,
  input  logic [N_SLOTS-1:0] i_slot_mask,
  input  logic               i_comp_hit,
  input  logic               i_clr_overrun,
  output logic               o_busy,
  output logic               o_comp_en,
  output logic [SLOT_W-1:0]  o_slot_idx,
  output logic               o_sel_en,
  output logic [SLOT_W-1:0]  o_sel_slot,
  output logic               o_sel_bg,
  output logic               o_px_valid,
  output logic               o_overrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SELECT  = 3'd3;
  localparam logic [2:0] S_STORE   = 3'd4;

  logic [2:0]         r_state;
  logic [N_SLOTS-1:0] r_mask;
  logic [SLOT_W-1:0]  r_idx;
  logic [SLOT_W-1:0]  r_sel_slot;
  logic               r_sel_bg;
  logic               r_busy;
  logic               r_comp_en;
  logic               r_sel_en;
  logic               r_px_valid;
  logic               r_overrun;

  logic               w_first_found;
  logic [SLOT_W-1:0]  w_first_idx;
  logic               w_up_found;
  logic [SLOT_W-1:0]  w_up_idx;
  logic               w_accept;
  logic               w_overrun_evt;
  logic [2:0]         w_next_state;
  logic [N_SLOTS-1:0] w_next_mask;
  logic [SLOT_W-1:0]  w_next_idx;
  logic [SLOT_W-1:0]  w_next_sel_slot;
  logic               w_next_sel_bg;

  // Lowest enabled slot of the incoming mask, and next enabled slot above r_idx.
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    w_up_found    = 1'b0;
    w_up_idx      = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (!w_first_found && i_slot_mask[SLOT_W'(i)]) begin
        w_first_found = 1'b1;
        w_first_idx   = SLOT_W'(i);
      end
      if (!w_up_found && r_mask[SLOT_W'(i)] && (SLOT_W'(i) > r_idx)) begin
        w_up_found = 1'b1;
        w_up_idx   = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    w_accept      = i_pixel_start && i_is_pixel &&
                    ((r_state == S_IDLE) || (r_state == S_STORE));
    w_overrun_evt = i_pixel_start &&
                    ((r_state == S_ISSUE) || (r_state == S_CAPTURE) || (r_state == S_SELECT));
    w_next_state    = r_state;
    w_next_mask     = r_mask;
    w_next_idx      = r_idx;
    w_next_sel_slot = r_sel_slot;
    w_next_sel_bg   = r_sel_bg;
    case (r_state)
      S_IDLE, S_STORE: begin
        w_next_state = S_IDLE;
        if (w_accept) begin
          w_next_mask = i_slot_mask;
          if (w_first_found) begin
            w_next_state = S_ISSUE;
            w_next_idx   = w_first_idx;
          end else begin
            w_next_state    = S_SELECT;
            w_next_sel_slot = '0;
            w_next_sel_bg   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (w_overrun_evt) begin
          w_next_state    = S_SELECT;
          w_next_sel_slot = '0;
          w_next_sel_bg   = 1'b1;
        end else begin
          w_next_state = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // An overrun abort takes precedence over a same-cycle hit.
        if (w_overrun_evt) begin
          w_next_state    = S_SELECT;
          w_next_sel_slot = '0;
          w_next_sel_bg   = 1'b1;
        end else if (i_comp_hit) begin
          w_next_state    = S_SELECT;
          w_next_sel_slot = r_idx;
          w_next_sel_bg   = 1'b0;
        end else if (w_up_found) begin
          w_next_state = S_ISSUE;
          w_next_idx   = w_up_idx;
        end else begin
          w_next_state    = S_SELECT;
          w_next_sel_slot = '0;
          w_next_sel_bg   = 1'b1;
        end
      end
      S_SELECT: w_next_state = S_STORE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align with the state visit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_mask     <= '0;
      r_idx      <= '0;
      r_sel_slot <= '0;
      r_sel_bg   <= 1'b0;
      r_busy     <= 1'b0;
      r_comp_en  <= 1'b0;
      r_sel_en   <= 1'b0;
      r_px_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_mask     <= w_next_mask;
      r_idx      <= w_next_idx;
      r_sel_slot <= w_next_sel_slot;
      r_sel_bg   <= w_next_sel_bg;
      r_busy     <= (w_next_state == S_ISSUE) || (w_next_state == S_CAPTURE) ||
                    (w_next_state == S_SELECT);
      r_comp_en  <= (w_next_state == S_ISSUE);
      r_sel_en   <= (w_next_state == S_SELECT);
      r_px_valid <= (w_next_state == S_STORE);
      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end else if (i_clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_comp_en  = r_comp_en;
  assign o_slot_idx = r_idx;
  assign o_sel_en   = r_sel_en;
  assign o_sel_slot = r_sel_slot;
  assign o_sel_bg   = r_sel_bg;
  assign o_px_valid = r_px_valid;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_drawing_slot_scheduler.sv
// Self-checking bench for drawing_slot_scheduler: directed scenarios plus
// random pixels checked against a timing model derived from the scan rules.
module tb_drawing_slot_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       pixel_start;
  logic       is_pixel;
  logic [7:0] slot_mask;
  logic       comp_hit;
  logic       clr_overrun;
  logic       busy;
  logic       comp_en;
  logic [2:0] slot_idx;
  logic       sel_en;
  logic [2:0] sel_slot;
  logic       sel_bg;
  logic       px_valid;
  logic       overrun;

  logic [7:0] tb_hits;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural comparator: answers for whichever slot is currently presented.
  assign comp_hit = tb_hits[slot_idx];

  drawing_slot_scheduler #(.N_SLOTS(8), .SLOT_W(3)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_pixel_start(pixel_start),
    .i_is_pixel   (is_pixel),
    .i_slot_mask  (slot_mask),
    .i_comp_hit   (comp_hit),
    .i_clr_overrun(clr_overrun),
    .o_busy       (busy),
    .o_comp_en    (comp_en),
    .o_slot_idx   (slot_idx),
    .o_sel_en     (sel_en),
    .o_sel_slot   (sel_slot),
    .o_sel_bg     (sel_bg),
    .o_px_valid   (px_valid),
    .o_overrun    (overrun)
  );

  task automatic start_pixel(input logic [7:0] mask, input logic isp);
    @(posedge clk); #1;
    pixel_start = 1'b1;
    is_pixel    = isp;
    slot_mask   = mask;
  endtask

  // Caller has asserted the accepted start in the current cycle (cycle t).
  task automatic scan_pixel(input logic [7:0] mask, input logic [7:0] hits,
                            input bit chain, input logic [7:0] nmask);
    int         comp_slot[$];
    int         win;
    int         sel_off;
    int         px_off;
    logic       e_ce;
    logic [2:0] e_idx;
    logic [2:0] e_sel;
    tb_hits = hits;
    win = -1;
    for (int s = 0; s < 8; s++) begin
      if (mask[s]) begin
        comp_slot.push_back(s);
        if (hits[s]) begin
          win = s;
          break;
        end
      end
    end
    sel_off = 1 + 2 * comp_slot.size();
    px_off  = sel_off + 1;
    for (int off = 1; off <= px_off; off++) begin
      @(posedge clk); #1;
      if (off == 1) begin
        pixel_start = 1'b0;
        is_pixel    = 1'($urandom_range(0, 1));
        slot_mask   = 8'($urandom);
      end
      if (chain && off == px_off) begin
        pixel_start = 1'b1;
        is_pixel    = 1'b1;
        slot_mask   = nmask;
      end
      e_ce = (off % 2 == 1) && (off < sel_off);
      checks++;
      if (comp_en !== e_ce) begin
        failures++;
        $display("FAIL scan_comp_en mask=%h off=%0d got=%b exp=%b", mask, off, comp_en, e_ce);
      end
      if (e_ce) begin
        e_idx = 3'(comp_slot[(off - 1) / 2]);
        checks++;
        if (slot_idx !== e_idx) begin
          failures++;
          $display("FAIL scan_slot_idx mask=%h off=%0d got=%0d exp=%0d", mask, off, slot_idx, e_idx);
        end
      end
      checks++;
      if (sel_en !== (off == sel_off)) begin
        failures++;
        $display("FAIL scan_sel_en mask=%h off=%0d got=%b exp=%b", mask, off, sel_en, off == sel_off);
      end
      if (off == sel_off) begin
        e_sel = (win >= 0) ? 3'(win) : 3'd0;
        checks++;
        if (sel_slot !== e_sel || sel_bg !== (win < 0)) begin
          failures++;
          $display("FAIL scan_select mask=%h hits=%h got slot=%0d bg=%b exp slot=%0d bg=%b",
                   mask, hits, sel_slot, sel_bg, e_sel, win < 0);
        end
      end
      checks++;
      if (px_valid !== (off == px_off) || busy !== (off <= sel_off) || overrun !== 1'b0) begin
        failures++;
        $display("FAIL scan_px_busy_ovr mask=%h off=%0d got px=%b busy=%b ovr=%b exp px=%b busy=%b ovr=0",
                 mask, off, px_valid, busy, overrun, off == px_off, off <= sel_off);
      end
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if ({busy, comp_en, slot_idx, sel_en, sel_slot, sel_bg, px_valid, overrun} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {busy, comp_en, slot_idx, sel_en, sel_slot, sel_bg, px_valid, overrun});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, comp_en, sel_en, px_valid, overrun} !== 5'd0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=00000", {busy, comp_en, sel_en, px_valid, overrun});
    end
  endtask

  task automatic test_hit_slot0;
    start_pixel(8'hFF, 1'b1);
    scan_pixel(8'hFF, 8'h01, 1'b0, 8'h00);
  endtask

  task automatic test_hit_slot3;
    start_pixel(8'hFF, 1'b1);
    scan_pixel(8'hFF, 8'h08, 1'b0, 8'h00);
  endtask

  task automatic test_sparse_miss;
    start_pixel(8'b0010_0100, 1'b1);
    scan_pixel(8'b0010_0100, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_empty_and_ignored;
    start_pixel(8'h00, 1'b1);
    scan_pixel(8'h00, 8'hFF, 1'b0, 8'h00);
    start_pixel(8'hFF, 1'b0);
    tb_hits = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      pixel_start = 1'b0;
      checks++;
      if ({busy, comp_en, sel_en, px_valid} !== 4'd0) begin
        failures++;
        $display("FAIL ignored_start cyc=%0d got=%b exp=0000", c, {busy, comp_en, sel_en, px_valid});
      end
    end
  endtask

  task automatic test_back_to_back;
    start_pixel(8'hFF, 1'b1);
    scan_pixel(8'hFF, 8'h01, 1'b1, 8'h10);
    scan_pixel(8'h10, 8'h00, 1'b1, 8'h00);
    scan_pixel(8'h00, 8'h00, 1'b0, 8'h00);
  endtask

  function automatic logic [7:0] rand_mask();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'h80;
    return 8'($urandom);
  endfunction

  task automatic test_random;
    logic [7:0] m, h, nm;
    bit         ch;
    m = rand_mask();
    start_pixel(m, 1'b1);
    for (int i = 0; i < 40; i++) begin
      nm = rand_mask();
      ch = (i < 39) && ($urandom_range(0, 2) == 0);
      h  = 8'($urandom) & 8'($urandom);
      scan_pixel(m, h, ch, nm);
      if (!ch && i < 39) start_pixel(nm, 1'b1);
      m = nm;
    end
  endtask

  task automatic test_overrun;
    // Abort in ISSUE of slot 1.
    start_pixel(8'hFF, 1'b1);
    tb_hits = 8'h00;
    @(posedge clk); #1; pixel_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; pixel_start = 1'b1; is_pixel = 1'($urandom_range(0, 1));
    @(posedge clk); #1; pixel_start = 1'b0;
    checks++;
    if (overrun !== 1'b1 || sel_en !== 1'b1 || sel_bg !== 1'b1 || sel_slot !== 3'd0 || comp_en !== 1'b0) begin
      failures++;
      $display("FAIL overrun_abort got ovr=%b sel_en=%b bg=%b slot=%0d ce=%b exp 1 1 1 0 0",
               overrun, sel_en, sel_bg, sel_slot, comp_en);
    end
    @(posedge clk); #1;
    checks++;
    if (px_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL overrun_store got px=%b busy=%b exp px=1 busy=0", px_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (px_valid !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got px=%b ovr=%b exp px=0 ovr=1", px_valid, overrun);
    end
    @(posedge clk); #1; clr_overrun = 1'b1;
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_before_clear got=%b exp=1", overrun);
    end
    @(posedge clk); #1; clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_cleared got=%b exp=0", overrun);
    end
    // Set and clear in the same cycle: set wins.
    start_pixel(8'hFF, 1'b1);
    tb_hits = 8'h04;
    @(posedge clk); #1; clr_overrun = 1'b1;
    @(posedge clk); #1; pixel_start = 1'b0; clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b1 || sel_en !== 1'b1 || sel_bg !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set_wins got ovr=%b sel_en=%b bg=%b exp 1 1 1", overrun, sel_en, sel_bg);
    end
    @(posedge clk); #1; clr_overrun = 1'b1;
    @(posedge clk); #1; clr_overrun = 1'b0;
    // Start during SELECT: flag only, result and timing unchanged, pixel dropped.
    start_pixel(8'hFF, 1'b1);
    tb_hits = 8'h04;
    for (int off = 1; off <= 10; off++) begin
      @(posedge clk); #1;
      pixel_start = (off == 7);
      is_pixel    = 1'b1;
      if (off == 7) begin
        checks++;
        if (sel_en !== 1'b1 || sel_slot !== 3'd2 || sel_bg !== 1'b0) begin
          failures++;
          $display("FAIL select_ovr_result got sel_en=%b slot=%0d bg=%b exp 1 2 0", sel_en, sel_slot, sel_bg);
        end
      end
      if (off == 8) begin
        checks++;
        if (px_valid !== 1'b1 || overrun !== 1'b1 || sel_slot !== 3'd2 || sel_bg !== 1'b0) begin
          failures++;
          $display("FAIL select_ovr_store got px=%b ovr=%b slot=%0d bg=%b exp 1 1 2 0",
                   px_valid, overrun, sel_slot, sel_bg);
        end
      end
      if (off >= 9) begin
        checks++;
        if (busy !== 1'b0 || comp_en !== 1'b0 || px_valid !== 1'b0) begin
          failures++;
          $display("FAIL select_ovr_dropped off=%0d got busy=%b ce=%b px=%b exp 0 0 0", off, busy, comp_en, px_valid);
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan;
    start_pixel(8'hFF, 1'b1);
    tb_hits = 8'h00;
    @(posedge clk); #1; pixel_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    checks++;
    if ({busy, comp_en, slot_idx, sel_en, sel_slot, sel_bg, px_valid, overrun} !== 12'd0) begin
      failures++;
      $display("FAIL reset_mid_scan got=%h exp=000", {busy, comp_en, slot_idx, sel_en, sel_slot, sel_bg, px_valid, overrun});
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, comp_en, sel_en, px_valid} !== 4'd0) begin
        failures++;
        $display("FAIL reset_abandon cyc=%0d got=%b exp=0000", c, {busy, comp_en, sel_en, px_valid});
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    pixel_start = 1'b0;
    is_pixel    = 1'b0;
    slot_mask   = 8'h00;
    clr_overrun = 1'b0;
    tb_hits     = 8'h00;
    repeat (3) @(posedge clk);
    test_reset();
    test_hit_slot0();
    test_hit_slot3();
    test_sparse_miss();
    test_empty_and_ignored();
    test_back_to_back();
    test_random();
    test_overrun();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
